// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

    // Binary width needed to hold 10^digits - 1.
    function automatic int unsigned bcd_bw(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return $clog2(p);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: subtract 3 from any digit >= 8.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit - ADJ_SUB) : i_digit;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using shift-right / subtract-3 iterations.
// Non-decimal digits skip the iterations and report err with a zero result.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter  int unsigned DIGITS = 3,
    localparam int unsigned BW     = bcd_bw(DIGITS),
    localparam int unsigned CW     = $clog2(BW + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BW-1:0]         bin_out,
    output logic                  err
);

    localparam int unsigned TW = 4 * DIGITS + BW;

    state_t                r_state;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [BW-1:0]         r_bin;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bin_out;
    logic                  r_err;
    logic                  r_done;

    logic [TW-1:0]         w_shift;
    logic [4*DIGITS-1:0]   w_bcd_adj;
    logic                  w_in_err;

    assign w_shift = {r_bcd, r_bin} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (w_shift[BW + 4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        w_in_err = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > DIGIT_MAX) begin
                w_in_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bcd     <= bcd_in;
                        r_bin     <= '0;
                        r_cnt     <= '0;
                        r_bin_out <= '0;
                        r_err     <= w_in_err;
                        r_state   <= w_in_err ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_shift[BW-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(BW - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // On error r_bin was cleared at capture, so bin_out stays zero.
                    r_bin_out <= r_bin;
                    r_done    <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign bin_out = r_bin_out;
    assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: cycle-level behavioural model plus directed vectors.
module tb_bcd_to_binary_seq;

    localparam int BW = 10;

    logic          clk;
    logic          rst;
    logic          start;
    logic [11:0]   bcd_in;
    logic          busy;
    logic          done;
    logic [BW-1:0] bin_out;
    logic          err;

    int n_checks;
    int n_fail;

    // Behavioural model: cycles of busy remaining, pending result, visible outputs.
    int            m_left;
    logic          m_done;
    logic [BW-1:0] m_bin;
    logic          m_err;
    logic [BW-1:0] m_pend;

    bcd_to_binary_seq #(.DIGITS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] d2, d1, d0;
        d2 = 4'(v / 100);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d2, d1, d0};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_bin  = '0;
            m_err  = 1'b0;
            m_pend = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_bin  = m_pend;
                end
            end else if (start) begin
                int  val;
                logic bad;
                val = 0;
                bad = 1'b0;
                for (int d = 2; d >= 0; d--) begin
                    int dig;
                    dig = int'(bcd_in[4*d +: 4]);
                    if (dig > 9) bad = 1'b1;
                    val = val * 10 + dig;
                end
                m_bin  = '0;
                m_err  = bad;
                m_pend = bad ? '0 : BW'(val);
                m_left = bad ? 1 : BW + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_done));
            check("bin_out", 32'(bin_out), 32'(m_bin));
            check("err", 32'(err), 32'(m_err));
            if (m_done && !m_err) begin
                check("bcd_reg_zero", 32'(dut.r_bcd), 32'd0);
            end
        end
    end

    task automatic run_conv(input logic [11:0] v, input int exp_bin, input logic exp_err,
                            input int exp_lat, input logic pin);
        int  lat;
        int  busy_cnt;
        logic got;
        @(posedge clk);
        #1;
        start  = 1'b1;
        bcd_in = v;
        @(posedge clk);
        lat = 1;
        #1;
        start  = 1'b0;
        bcd_in = ~v;
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check("done_seen", 32'(got), 32'd1);
        if (pin) begin
            check("lit_bin_out", 32'(bin_out), 32'(exp_bin));
            check("lit_err", 32'(err), 32'(exp_err));
            check("lit_latency", 32'(lat), 32'(exp_lat));
            check("lit_busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
        end else begin
            check("sweep_bin_out", 32'(bin_out), 32'(exp_bin));
        end
    endtask

    initial begin
        int n_done;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        bcd_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bin_out", 32'(bin_out), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        run_conv(12'h999, 999, 1'b0, 12, 1'b1);
        check("lit_999_hex", 32'(bin_out), 32'h3E7);
        run_conv(12'h000, 0, 1'b0, 12, 1'b1);
        run_conv(12'h255, 'hFF, 1'b0, 12, 1'b1);
        run_conv(12'h100, 'h64, 1'b0, 12, 1'b1);
        run_conv(12'h1A3, 0, 1'b1, 2, 1'b1);
        run_conv(12'h042, 42, 1'b0, 12, 1'b1);

        // start held high, bcd_in changing every cycle
        n_done = 0;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            #1;
            start  = 1'b1;
            bcd_in = to_bcd((i * 37 + 11) % 1000);
            @(negedge clk);
            if (done) n_done++;
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        check("held_start_done_count", 32'(n_done), 32'd3);
        repeat (16) @(posedge clk);

        // abort mid-SHIFT with reset
        @(posedge clk);
        #1;
        start  = 1'b1;
        bcd_in = 12'h512;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bin_out", 32'(bin_out), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        run_conv(12'h512, 'h200, 1'b0, 12, 1'b1);

        for (int v = 0; v < 1000; v++) begin
            run_conv(to_bcd(v), v, 1'b0, 12, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
